// File: rtl/stopwatch_timer_ctrl_if.sv
// Handshake bundle for the stopwatch/timer controller: control requests in,
// count/status and lap-buffer view out.
interface stopwatch_timer_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             tick;
    logic             start;
    logic             stop;
    logic             reset;
    logic             mode;
    logic [CNT_W-1:0] load_val;
    logic             lap;
    logic             lap_rd;
    logic [CNT_W-1:0] count;
    logic [1:0]       status;
    logic             enable_count;
    logic             expired;
    logic             wrap;
    logic [CNT_W-1:0] lap_data;
    logic             lap_valid;
    logic             lap_full;
    logic             lap_ovf;

    modport master (
        output tick, start, stop, reset, mode, load_val, lap, lap_rd,
        input  count, status, enable_count, expired, wrap,
               lap_data, lap_valid, lap_full, lap_ovf
    );

    modport slave (
        input  tick, start, stop, reset, mode, load_val, lap, lap_rd,
        output count, status, enable_count, expired, wrap,
               lap_data, lap_valid, lap_full, lap_ovf
    );
endinterface

// File: rtl/stopwatch_timer_ctrl.sv
// Stopwatch / countdown timer FSM with a show-ahead lap capture FIFO.
// Any return to IDLE clears the count, sticky flags and the lap buffer.
module stopwatch_timer_ctrl #(
    parameter int CNT_W     = 16,
    parameter int LAP_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    stopwatch_timer_ctrl_if.slave bus
);
    localparam int            PW           = $clog2(LAP_DEPTH);
    localparam logic [PW:0]   LAP_FULL_CNT = (PW+1)'(LAP_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_RUNNING = 2'b01,
        S_PAUSED  = 2'b10,
        S_EXPIRED = 2'b11
    } state_t;

    state_t           r_state;
    logic             r_mode;
    logic [CNT_W-1:0] r_count;
    logic             r_expired;
    logic             r_wrap;
    logic             r_lap_ovf;
    logic [CNT_W-1:0] r_lap_mem [LAP_DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_lap_cnt;

    logic             w_lap_valid;
    logic             w_lap_full;
    logic             w_lap_en;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic             w_load_zero;
    logic [CNT_W-1:0] w_load_val;

    assign w_lap_valid = (r_lap_cnt != '0);
    assign w_lap_full  = (r_lap_cnt == LAP_FULL_CNT);
    assign w_lap_en    = bus.lap && (r_state == S_RUNNING || r_state == S_PAUSED);
    assign w_pop       = bus.lap_rd && w_lap_valid;
    // A same-cycle pop frees the slot, so a full buffer still accepts the push.
    assign w_push      = w_lap_en && (!w_lap_full || w_pop);
    assign w_drop      = w_lap_en && w_lap_full && !w_pop;
    assign w_load_zero = bus.mode && (bus.load_val == '0);
    assign w_load_val  = bus.mode ? bus.load_val : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_mode    <= 1'b0;
            r_count   <= '0;
            r_expired <= 1'b0;
            r_wrap    <= 1'b0;
            r_lap_ovf <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_lap_cnt <= '0;
        end else begin
            r_expired <= 1'b0;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_push && !w_pop)      r_lap_cnt <= r_lap_cnt + (PW+1)'(1);
            else if (w_pop && !w_push) r_lap_cnt <= r_lap_cnt - (PW+1)'(1);
            if (w_drop) r_lap_ovf <= 1'b1;

            if (bus.reset) begin
                // Flush assignments here override the FIFO updates above.
                r_state   <= S_IDLE;
                r_count   <= '0;
                r_wrap    <= 1'b0;
                r_lap_ovf <= 1'b0;
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_lap_cnt <= '0;
            end else begin
                case (r_state)
                    S_IDLE, S_EXPIRED: begin
                        if (bus.start) begin
                            r_mode  <= bus.mode;
                            r_count <= w_load_val;
                            if (w_load_zero) begin
                                r_state   <= S_EXPIRED;
                                r_expired <= 1'b1;
                            end else begin
                                r_state <= S_RUNNING;
                            end
                        end
                    end
                    S_RUNNING: begin
                        if (bus.stop) begin
                            r_state <= S_PAUSED;
                        end else if (bus.tick) begin
                            if (!r_mode) begin
                                r_count <= r_count + CNT_W'(1);
                                if (r_count == '1) r_wrap <= 1'b1;
                            end else if (r_count == CNT_W'(1)) begin
                                r_count   <= '0;
                                r_state   <= S_EXPIRED;
                                r_expired <= 1'b1;
                            end else begin
                                r_count <= r_count - CNT_W'(1);
                            end
                        end
                    end
                    S_PAUSED: begin
                        if (bus.start) r_state <= S_RUNNING;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Storage needs no reset: lap_data is masked while the buffer is empty.
    always_ff @(posedge clk) begin
        if (rst_n && w_push) r_lap_mem[r_wr_ptr] <= r_count;
    end

    assign bus.count        = r_count;
    assign bus.status       = r_state;
    assign bus.enable_count = (r_state == S_RUNNING);
    assign bus.expired      = r_expired;
    assign bus.wrap         = r_wrap;
    assign bus.lap_data     = w_lap_valid ? r_lap_mem[r_rd_ptr] : '0;
    assign bus.lap_valid    = w_lap_valid;
    assign bus.lap_full     = w_lap_full;
    assign bus.lap_ovf      = r_lap_ovf;
endmodule

// File: tb/tb_stopwatch_timer_ctrl.sv
// Directed bench for stopwatch_timer_ctrl (4-bit count so wrap is reachable).
module tb_stopwatch_timer_ctrl;
    localparam int CW = 4;
    localparam int LD = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   vecs = 0;
    int   miss = 0;

    always #5 clk = ~clk;

    stopwatch_timer_ctrl_if #(.CNT_W(CW)) bus ();

    stopwatch_timer_ctrl #(.CNT_W(CW), .LAP_DEPTH(LD)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            bus.tick = 1'b1; cyc(); bus.tick = 1'b0;
        end
    endtask

    task automatic go_idle();
        bus.reset = 1'b1; cyc(); bus.reset = 1'b0;
    endtask

    task automatic do_start(input logic m, input logic [CW-1:0] lv);
        bus.mode = m; bus.load_val = lv; bus.start = 1'b1; cyc(); bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cyc(); cyc(); rst_n = 1'b1;
        vecs++; if (bus.status !== 2'b00) begin miss++; $display("FAIL rst_status got %b want 00", bus.status); end
        vecs++; if (bus.count !== 4'd0) begin miss++; $display("FAIL rst_count got %0d want 0", bus.count); end
        vecs++; if (bus.enable_count !== 1'b0) begin miss++; $display("FAIL rst_en got %b want 0", bus.enable_count); end
        vecs++; if (bus.lap_valid !== 1'b0) begin miss++; $display("FAIL rst_lap_valid got %b want 0", bus.lap_valid); end
    endtask

    task automatic test_count_up();
        do_start(1'b0, 4'd9);
        vecs++; if (bus.status !== 2'b01 || bus.count !== 4'd0) begin miss++; $display("FAIL up_start got st=%b cnt=%0d want 01/0", bus.status, bus.count); end
        ticks(5);
        vecs++; if (bus.count !== 4'd5) begin miss++; $display("FAIL up_5ticks got %0d want 5", bus.count); end
        bus.start = 1'b1; cyc(); bus.start = 1'b0;
        vecs++; if (bus.count !== 4'd5) begin miss++; $display("FAIL up_start_ignored got %0d want 5", bus.count); end
        bus.stop = 1'b1; bus.tick = 1'b1; cyc(); bus.stop = 1'b0; bus.tick = 1'b0;
        ticks(3);
        vecs++; if (bus.count !== 4'd5 || bus.status !== 2'b10 || bus.enable_count !== 1'b0) begin miss++; $display("FAIL up_paused got cnt=%0d st=%b en=%b want 5/10/0", bus.count, bus.status, bus.enable_count); end
        do_start(1'b1, 4'd9);
        ticks(2);
        vecs++; if (bus.count !== 4'd7 || bus.status !== 2'b01) begin miss++; $display("FAIL up_resume got cnt=%0d st=%b want 7/01", bus.count, bus.status); end
    endtask

    task automatic test_count_down();
        go_idle();
        do_start(1'b1, 4'd3);
        vecs++; if (bus.count !== 4'd3) begin miss++; $display("FAIL dn_load got %0d want 3", bus.count); end
        ticks(3);
        vecs++; if (bus.count !== 4'd0 || bus.status !== 2'b11 || bus.expired !== 1'b1) begin miss++; $display("FAIL dn_expire got cnt=%0d st=%b exp=%b want 0/11/1", bus.count, bus.status, bus.expired); end
        cyc();
        vecs++; if (bus.expired !== 1'b0) begin miss++; $display("FAIL dn_exp_pulse got %b want 0", bus.expired); end
        ticks(2);
        vecs++; if (bus.count !== 4'd0 || bus.status !== 2'b11) begin miss++; $display("FAIL dn_hold got cnt=%0d st=%b want 0/11", bus.count, bus.status); end
        do_start(1'b0, 4'd7);
        vecs++; if (bus.count !== 4'd0 || bus.status !== 2'b01) begin miss++; $display("FAIL dn_restart got cnt=%0d st=%b want 0/01", bus.count, bus.status); end
        go_idle();
        do_start(1'b1, 4'd0);
        vecs++; if (bus.status !== 2'b11 || bus.expired !== 1'b1) begin miss++; $display("FAIL dn_zero_load got st=%b exp=%b want 11/1", bus.status, bus.expired); end
    endtask

    task automatic test_wrap();
        go_idle();
        do_start(1'b0, 4'd0);
        ticks(15);
        vecs++; if (bus.count !== 4'd15 || bus.wrap !== 1'b0) begin miss++; $display("FAIL wrap_pre got cnt=%0d wrap=%b want 15/0", bus.count, bus.wrap); end
        ticks(2);
        vecs++; if (bus.count !== 4'd1 || bus.wrap !== 1'b1) begin miss++; $display("FAIL wrap_post got cnt=%0d wrap=%b want 1/1", bus.count, bus.wrap); end
        go_idle();
        vecs++; if (bus.wrap !== 1'b0 || bus.status !== 2'b00 || bus.count !== 4'd0) begin miss++; $display("FAIL wrap_clear got wrap=%b st=%b cnt=%0d want 0/00/0", bus.wrap, bus.status, bus.count); end
    endtask

    task automatic test_laps();
        go_idle();
        do_start(1'b0, 4'd0);
        for (int i = 1; i <= 5; i++) begin
            ticks(1);
            bus.lap = 1'b1; cyc(); bus.lap = 1'b0;
        end
        vecs++; if (bus.lap_full !== 1'b1 || bus.lap_ovf !== 1'b1) begin miss++; $display("FAIL lap_full_ovf got full=%b ovf=%b want 1/1", bus.lap_full, bus.lap_ovf); end
        for (int i = 1; i <= 4; i++) begin
            vecs++; if (bus.lap_data !== CW'(i)) begin miss++; $display("FAIL lap_pop got %0d want %0d", bus.lap_data, i); end
            bus.lap_rd = 1'b1; cyc(); bus.lap_rd = 1'b0;
        end
        vecs++; if (bus.lap_valid !== 1'b0 || bus.lap_data !== 4'd0 || bus.lap_full !== 1'b0) begin miss++; $display("FAIL lap_empty got v=%b d=%0d f=%b want 0/0/0", bus.lap_valid, bus.lap_data, bus.lap_full); end
    endtask

    task automatic test_back_to_back();
        go_idle();
        vecs++; if (bus.lap_ovf !== 1'b0) begin miss++; $display("FAIL b2b_ovf_clear got %b want 0", bus.lap_ovf); end
        do_start(1'b0, 4'd0);
        bus.lap = 1'b1; bus.tick = 1'b1;
        repeat (4) cyc();
        bus.lap = 1'b0; bus.tick = 1'b0;
        vecs++; if (bus.lap_data !== 4'd0 || bus.lap_full !== 1'b1 || bus.count !== 4'd4) begin miss++; $display("FAIL b2b_preupdate got d=%0d f=%b cnt=%0d want 0/1/4", bus.lap_data, bus.lap_full, bus.count); end
        bus.lap = 1'b1; bus.lap_rd = 1'b1; cyc(); bus.lap = 1'b0; bus.lap_rd = 1'b0;
        vecs++; if (bus.lap_full !== 1'b1 || bus.lap_ovf !== 1'b0 || bus.lap_data !== 4'd1) begin miss++; $display("FAIL b2b_full_rw got f=%b ovf=%b d=%0d want 1/0/1", bus.lap_full, bus.lap_ovf, bus.lap_data); end
        for (int i = 1; i <= 4; i++) begin
            vecs++; if (bus.lap_data !== CW'(i)) begin miss++; $display("FAIL b2b_drain got %0d want %0d", bus.lap_data, i); end
            bus.lap_rd = 1'b1; cyc(); bus.lap_rd = 1'b0;
        end
        bus.lap = 1'b1; bus.lap_rd = 1'b1; cyc(); bus.lap = 1'b0; bus.lap_rd = 1'b0;
        vecs++; if (bus.lap_valid !== 1'b1 || bus.lap_data !== 4'd4) begin miss++; $display("FAIL b2b_empty_rw got v=%b d=%0d want 1/4", bus.lap_valid, bus.lap_data); end
        go_idle();
        bus.lap = 1'b1; cyc(); bus.lap = 1'b0;
        vecs++; if (bus.lap_valid !== 1'b0) begin miss++; $display("FAIL b2b_idle_lap got %b want 0", bus.lap_valid); end
    endtask

    task automatic test_priority();
        go_idle();
        do_start(1'b0, 4'd0);
        ticks(2);
        bus.stop = 1'b1; bus.reset = 1'b1; bus.tick = 1'b1; cyc();
        bus.stop = 1'b0; bus.reset = 1'b0; bus.tick = 1'b0;
        vecs++; if (bus.status !== 2'b00 || bus.count !== 4'd0) begin miss++; $display("FAIL pri_run got st=%b cnt=%0d want 00/0", bus.status, bus.count); end
        do_start(1'b0, 4'd0);
        ticks(3);
        bus.stop = 1'b1; cyc(); bus.stop = 1'b0;
        bus.start = 1'b1; bus.reset = 1'b1; cyc(); bus.start = 1'b0; bus.reset = 1'b0;
        vecs++; if (bus.status !== 2'b00 || bus.count !== 4'd0) begin miss++; $display("FAIL pri_pause got st=%b cnt=%0d want 00/0", bus.status, bus.count); end
    endtask

    task automatic test_rstn_mid();
        go_idle();
        do_start(1'b0, 4'd0);
        ticks(1); bus.lap = 1'b1; cyc(); bus.lap = 1'b0;
        ticks(1); bus.lap = 1'b1; cyc(); bus.lap = 1'b0;
        ticks(1);
        rst_n = 1'b0; bus.tick = 1'b1; bus.lap = 1'b1; cyc();
        rst_n = 1'b1; bus.tick = 1'b0; bus.lap = 1'b0;
        vecs++; if (bus.status !== 2'b00 || bus.count !== 4'd0 || bus.enable_count !== 1'b0 || bus.expired !== 1'b0 || bus.wrap !== 1'b0) begin miss++; $display("FAIL rstn_core got st=%b cnt=%0d en=%b exp=%b wrap=%b want 00/0/0/0/0", bus.status, bus.count, bus.enable_count, bus.expired, bus.wrap); end
        vecs++; if (bus.lap_valid !== 1'b0 || bus.lap_full !== 1'b0 || bus.lap_ovf !== 1'b0 || bus.lap_data !== 4'd0) begin miss++; $display("FAIL rstn_lap got v=%b f=%b ovf=%b d=%0d want 0/0/0/0", bus.lap_valid, bus.lap_full, bus.lap_ovf, bus.lap_data); end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.tick = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.reset = 1'b0;
        bus.mode = 1'b0; bus.load_val = '0; bus.lap = 1'b0; bus.lap_rd = 1'b0;
        test_reset();
        test_count_up();
        test_count_down();
        test_wrap();
        test_laps();
        test_back_to_back();
        test_priority();
        test_rstn_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule

// File: doc/stopwatch_timer_ctrl.md
STOPWATCH_TIMER_CTRL -- requirements
Module: stopwatch_timer_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of the count value.
REQ-002 Parameter LAP_DEPTH, default 4 (power of 2, >=2), number of lap capture entries.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 tick  input  1  count-advance pulse, one clk wide.
REQ-006 start  input  1  start/resume request.
REQ-007 stop  input  1  pause request.
REQ-008 reset  input  1  soft reset request to IDLE.
REQ-009 mode  input  1  0 = count-up stopwatch, 1 = count-down timer; sampled only on start from IDLE or EXPIRED.
REQ-010 load_val  input  CNT_W  count-down preload; sampled with mode.
REQ-011 lap  input  1  capture current count into lap buffer.
REQ-012 lap_rd  input  1  pop head of lap buffer.
REQ-013 count  output  CNT_W  current count register.
REQ-014 status  output  2  state encoding: IDLE 00, RUNNING 01, PAUSED 10, EXPIRED 11.
REQ-015 enable_count  output  1  high exactly when state is RUNNING.
REQ-016 expired  output  1  one-cycle pulse on entry to EXPIRED.
REQ-017 wrap  output  1  sticky; count-up wrapped past all-ones.
REQ-018 lap_data  output  CNT_W  head of lap buffer (show-ahead); 0 when empty.
REQ-019 lap_valid  output  1  lap buffer non-empty.
REQ-020 lap_full  output  1  lap buffer holds LAP_DEPTH entries.
REQ-021 lap_ovf  output  1  sticky; a lap was dropped because the buffer was full.

Function
REQ-022 The block SHALL implement a four-state FSM (IDLE, RUNNING, PAUSED, EXPIRED); status SHALL equal the state register.
REQ-023 IDLE: start -> RUNNING; count loads 0 (mode 0) or load_val (mode 1); latched mode held until the next start from IDLE/EXPIRED.
REQ-024 IDLE, mode 1, load_val == 0, start -> EXPIRED directly with expired pulse.
REQ-025 RUNNING priority: reset > stop > tick; reset -> IDLE, stop -> PAUSED; tick ignored in the same cycle as reset or stop.
REQ-026 RUNNING, tick, mode 0: count+1 modulo 2^CNT_W; all-ones to 0 sets wrap.
REQ-027 RUNNING, tick, mode 1: count-1; when count == 1, count becomes 0, state -> EXPIRED, expired high next cycle only.
REQ-028 PAUSED: count holds; reset -> IDLE takes priority over start -> RUNNING (no reload).
REQ-029 EXPIRED: count holds 0; reset -> IDLE; start (reset low) -> reload per REQ-023 and RUNNING.
REQ-030 start while RUNNING and stop while PAUSED/IDLE/EXPIRED SHALL be ignored.
REQ-031 Every entry to IDLE SHALL clear count, wrap, lap_ovf and flush the lap buffer in the same edge.
REQ-032 lap in RUNNING or PAUSED SHALL push the pre-update count value (value before any same-cycle tick); lap in IDLE/EXPIRED ignored.
REQ-033 lap with buffer full and no lap_rd: entry dropped, lap_ovf set.
REQ-034 lap and lap_rd in the same cycle: pop and push both occur, occupancy unchanged, including when full.
REQ-035 lap_rd when empty SHALL be ignored; buffer pointers wrap modulo LAP_DEPTH.
REQ-036 Outputs update one clk after the qualifying input edge; enable_count decoded from the registered state.

Reset
REQ-037 rst_n low at a rising edge SHALL force state IDLE, count 0, enable_count 0, expired 0, wrap 0, lap buffer empty, lap_valid 0, lap_full 0, lap_ovf 0, lap_data 0.
REQ-038 rst_n overrides all other inputs, including mid-count and mid-lap operations.

Verification
REQ-039 mode 0, start, 5 ticks, stop, 3 ticks -> count 5, status 10, enable_count 0.
REQ-040 mode 1, load_val 3, start, 3 ticks -> count 0, status 11, expired high one cycle; further ticks leave count 0.
REQ-041 CNT_W 4, mode 0, start, 16 ticks -> count 0, wrap 1; reset -> wrap 0, status 00.
REQ-042 Laps at counts 1,2,3,4,5 (LAP_DEPTH 4) -> lap_full 1, lap_ovf 1; 4 lap_rd return 1,2,3,4, then lap_valid 0.
REQ-043 RUNNING, stop and reset same cycle -> IDLE; PAUSED, start and reset same cycle -> IDLE, count 0.
REQ-044 rst_n low for one edge mid-RUNNING with 2 laps buffered -> all outputs at REQ-037 values next cycle.
